// File: rtl/sum_accumulator.sv
// Burst accumulator: sums COUNT unsigned samples, presents the total with a sticky overflow flag.
// Define SUM_ACC_SAT_EN to clamp the total at 2^ACC_W-1 on overflow instead of wrapping.
module sum_accumulator #(
  parameter int DATA_W = 5,
  parameter int ACC_W  = 7,
  parameter int COUNT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  logic [ACC_W:0]    sum_full;
  logic              sum_ovf;
  logic [ACC_W-1:0]  sum_val;

  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return {1'b0, a} + (ACC_W+1)'(b);
  endfunction

`ifdef SUM_ACC_SAT_EN
  function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W-1:0] s,
                                                 input logic ovf);
    return ovf ? {ACC_W{1'b1}} : s;
  endfunction
`endif

  always_comb begin
    sum_full = add_ext(acc_q, in_data);
    // Overflow is sticky across the burst, so once set the clamp holds too.
    sum_ovf  = ovf_q | sum_full[ACC_W];
`ifdef SUM_ACC_SAT_EN
    sum_val  = sat_clamp(sum_full[ACC_W-1:0], sum_ovf);
`else
    sum_val  = sum_full[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (cnt_q == LAST_CNT) begin
              out_data_d = sum_val;
              out_ovf_d  = sum_ovf;
              state_d    = HOLD;
              acc_d      = '0;
              cnt_d      = '0;
              ovf_d      = 1'b0;
            end else begin
              acc_d = sum_val;
              cnt_d = cnt_q + 8'd1;
              ovf_d = sum_ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a reference model pushes expected burst results into a
// queue, compared whenever the DUT presents a result.
module tb_sum_accumulator;

  localparam int DATA_W = 5;
  localparam int ACC_W  = 7;
  localparam int COUNT  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             ovf;
  } result_t;

  result_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      mdl_sum = 0;
  int      mdl_cnt = 0;
  bit      mdl_hold = 1'b0;

  sum_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic result_t make_result(input int total);
    result_t r;
    r.ovf = (total > (1 << ACC_W) - 1);
`ifdef SUM_ACC_SAT_EN
    r.data = r.ovf ? ACC_W'((1 << ACC_W) - 1) : ACC_W'(total);
`else
    r.data = ACC_W'(total % (1 << ACC_W));
`endif
    return r;
  endfunction

  // One clock cycle: drive, advance the model on the edge, then check outputs just after it.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic clr, input logic rdy);
    result_t front;
    in_valid  = v;
    in_data   = d;
    clear     = clr;
    out_ready = rdy;
    @(posedge clk);
    if (clr) begin
      mdl_sum = 0;
      mdl_cnt = 0;
      if (mdl_hold && exp_q.size() > 0) void'(exp_q.pop_front());
      mdl_hold = 1'b0;
    end else if (mdl_hold) begin
      if (rdy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mdl_hold = 1'b0;
      end
    end else if (v) begin
      mdl_sum += int'(d);
      mdl_cnt++;
      if (mdl_cnt == COUNT) begin
        exp_q.push_back(make_result(mdl_sum));
        mdl_hold = 1'b1;
        mdl_sum  = 0;
        mdl_cnt  = 0;
      end
    end
    #1;
    check("in_ready", int'(in_ready), int'(!mdl_hold));
    check("out_valid", int'(out_valid), int'(mdl_hold));
    if (mdl_hold) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        front = exp_q[0];
        check("out_data", int'(out_data), int'(front.data));
        check("out_ovf", int'(out_ovf), int'(front.ovf));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_ovf"}, int'(out_ovf), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int vals[8];
    // Reset state
    #2;
    check_reset_outputs("rst_init");
    #10;
    rst_n = 1'b1;

    // Basic burst, consumer always ready; result one cycle after 8th accept, then ACCUM again
    vals = '{11, 8, 10, 7, 3, 4, 5, 6};
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(vals[i]), 1'b0, 1'b1);
    check("burst54_data", int'(out_data), 54);
    step(1'b0, '0, 1'b0, 1'b1);

    // Overflow burst: 8 x 31 = 248
    for (int i = 0; i < 8; i++) step(1'b1, 5'd31, 1'b0, 1'b0);
    check("ovf_flag", int'(out_ovf), 1);
`ifdef SUM_ACC_SAT_EN
    check("ovf_data", int'(out_data), 127);
`else
    check("ovf_data", int'(out_data), 120);
`endif
    step(1'b0, '0, 1'b0, 1'b1);

    // Back-pressure: held result stays put while upstream keeps offering 9s
    for (int i = 0; i < 8; i++) step(1'b1, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd9, 1'b0, 1'b0);
    check("bp_data", int'(out_data), 32);
    step(1'b1, 5'd9, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 5'd1, 1'b0, 1'b0);
    check("bp_next_data", int'(out_data), 8);
    step(1'b0, '0, 1'b0, 1'b1);

    // Clear after three samples; the sample offered with clear is dropped
    for (int i = 0; i < 3; i++) step(1'b1, 5'd5, 1'b0, 1'b0);
    step(1'b1, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 5'd1, 1'b0, 1'b0);
    check("clear_data", int'(out_data), 8);
    check("clear_ovf", int'(out_ovf), 0);
    // Clear while holding discards the result
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges mid-burst
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    mdl_sum  = 0;
    mdl_cnt  = 0;
    mdl_hold = 1'b0;
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 5'd2, 1'b0, 1'b0);
    check("rst_next_data", int'(out_data), 16);
    step(1'b0, '0, 1'b0, 1'b1);

    // in_valid toggling: only odd cycles carry valid samples (values 2,4,...,16)
    for (int i = 0; i < 16; i++) step(1'b1 & i[0], DATA_W'(i + 1), 1'b0, 1'b0);
    check("toggle_data", int'(out_data), 72);
    step(1'b0, '0, 1'b0, 1'b1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 5, meaning the width of each incoming adder sum.
REQ-002 The block SHALL have parameter ACC_W, default 7, meaning the width of the running total.
REQ-003 The block SHALL have parameter COUNT, default 8, meaning the number of samples per burst (legal range 2..255).
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-006 The block SHALL have port clear  input  1  meaning synchronous abort of the current burst.
REQ-007 The block SHALL have port in_valid  input  1  meaning in_data holds a sum from the upstream adder.
REQ-008 The block SHALL have port in_data  input  DATA_W  meaning the unsigned sum, i.e. the adder's Z output.
REQ-009 The block SHALL have port in_ready  output  1  meaning the block accepts a sample this cycle.
REQ-010 The block SHALL have port out_valid  output  1  meaning out_data/out_ovf hold a completed burst result.
REQ-011 The block SHALL have port out_ready  input  1  meaning the consumer takes the result this cycle.
REQ-012 The block SHALL have port out_data  output  ACC_W  meaning the burst total.
REQ-013 The block SHALL have port out_ovf  output  1  meaning the burst total exceeded 2^ACC_W-1.

Function
REQ-014 The block SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 The block SHALL accept a sample on any edge in ACCUM with in_valid=1 and clear=0; acc <= acc + zero-extended in_data, cnt <= cnt+1.
REQ-016 The block SHALL, on the edge accepting the COUNT-th sample, register the final total and overflow into out_data/out_ovf and enter HOLD; out_valid rises the cycle after that edge (latency 1).
REQ-017 The block SHALL hold out_data and out_ovf stable throughout HOLD.
REQ-018 The block SHALL, on an edge in HOLD with out_ready=1, return to ACCUM with acc=0, cnt=0, ovf=0; no sample is accepted on that edge.
REQ-019 The block SHALL compute the sum at ACC_W+1 bits; a carry out of bit ACC_W-1 sets a sticky per-burst ovf flag.
REQ-020 The block SHALL, without saturation, store the sum modulo 2^ACC_W.
REQ-021 The block SHALL, on clear=1 in any state, set acc=0, cnt=0, ovf=0, state=ACCUM, out_valid=0 next cycle; clear has priority over accept and out_ready, and the sample presented on that edge is dropped.
REQ-022 The block SHALL ignore in_valid while in HOLD (back-pressure via in_ready=0).
REQ-023 The block SHALL leave acc and cnt unchanged on ACCUM edges with in_valid=0.

Reset
REQ-024 The block SHALL, while rst_n=0, asynchronously force state=ACCUM, acc=0, cnt=0, ovf=0, out_data=0, out_ovf=0, out_valid=0, in_ready=1.
REQ-025 The block SHALL, on rst_n asserted mid-burst or in HOLD, discard the partial or held result entirely.
REQ-026 The block SHALL accept a sample on the first rising edge after rst_n deasserts.

Configuration
REQ-027 The block SHALL, when macro SUM_ACC_SAT_EN is defined, clamp the total to 2^ACC_W-1 on overflow, stay clamped for the rest of the burst, and still assert out_ovf.
REQ-028 The block SHALL, when SUM_ACC_SAT_EN is undefined, wrap the total modulo 2^ACC_W per REQ-020; out_ovf behaves identically in both builds.

Verification
REQ-029 The bench SHALL cover: samples 11,8,10,7,3,4,5,6 with out_ready=1 -> out_valid one cycle after the 8th accept, out_data=54, out_ovf=0, back to ACCUM next edge.
REQ-030 The bench SHALL cover: eight samples of 31 -> out_ovf=1, out_data=120 (wrap) or 127 (SUM_ACC_SAT_EN).
REQ-031 The bench SHALL cover: burst completes with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data stable, no samples consumed until the out_ready=1 edge.
REQ-032 The bench SHALL cover: clear pulsed after 3 samples, then eight samples of 1 -> out_data=8, out_ovf=0.
REQ-033 The bench SHALL cover: rst_n pulsed low between clock edges mid-burst -> outputs zero immediately; the next full burst of eight 2s gives out_data=16.
REQ-034 The bench SHALL cover: in_valid toggling every other cycle across a burst -> only cycles with in_valid=1 counted; result equals the sum of the valid samples.
